fp_mult_seq: RTL and testbench
==============================

FP_MULT_SEQ -- requirements
Module: fp_mult_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- EXP_WIDTH, 8, exponent field width E.
- MANT_WIDTH, 23, stored mantissa width M.
- TRUNC_BITS, 0, number of low product bits forced to zero (approximate mode), 0..M.
- BIT_WIDTH, 1+E+M, derived operand/result width; not overridden.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, the only clock.
- rst, in, 1, reset, synchronous and active-high.
- in_valid, in, 1, operands valid.
- in_ready, out, 1, block can accept operands.
- a_operand, in, BIT_WIDTH, multiplicand {sign, exp, mant}.
- b_operand, in, BIT_WIDTH, multiplier {sign, exp, mant}.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- result, out, BIT_WIDTH, product.
- exception, out, 1, an operand exponent is all-ones.
- overflow, out, 1, result saturated to infinity.
- underflow, out, 1, result flushed to signed zero.
- zero, out, 1, exact zero product.

Function
REQ-003 The block SHALL be a single-issue iterative multiplier with FSM states IDLE, MUL, NORM, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; an accept occurs on a clock edge with in_valid=1 and in_ready=1, which SHALL register both operands and go to MUL.
REQ-005 In IDLE with in_valid=0, the FSM SHALL stay in IDLE.
REQ-006 Hidden bit: each operand's significand SHALL be {1,mant} if its exponent field is nonzero, else {0,mant}. The significand width is H=M+1.
REQ-007 MUL SHALL last exactly H cycles.
- Each cycle: one radix-2 shift-add step, multiplier LSB first, into a 2H-bit accumulator.
- A modulo-H step counter controls the step; it returns to 0 on exit.
REQ-008 Product bits [TRUNC_BITS-1:0] SHALL be forced to 0 before normalisation.
REQ-009 NORM SHALL take one cycle and perform the following:
- norm = product[2H-1]; if norm=0, shift the product left by 1.
- guard = normalised bit [M]; sticky = OR of normalised bits [M-1:0].
- mant = normalised bits [2H-2:M+1] + (guard & sticky).
REQ-010 If the rounding increment carries out of M bits, mant SHALL become 0 and the exponent SHALL be incremented by 1.
REQ-011 Exponent arithmetic SHALL be signed, on at least E+2 bits: e = expA + expB - (2^(E-1)-1) + norm + round_carry.
REQ-012 Result priority SHALL be as follows:
- exception: result = all zeros.
- else zero (full 2H-bit product == 0): {sign, 0}.
- else overflow (e >= 2^E-1): {sign, all-ones exponent, 0 mantissa}.
- else underflow (e <= 0): {sign, 0}.
- else {sign, e[E-1:0], mant}.
sign = signA XOR signB.
REQ-013 Flags SHALL be mutually exclusive and follow the priority in REQ-012.
REQ-014 The flags SHALL be registered with result at NORM exit.
REQ-015 DONE SHALL assert out_valid.
- result and the flags SHALL stay stable while out_valid=1 and out_ready=0.
- On an edge with out_ready=1, the FSM SHALL return to IDLE.
REQ-016 out_valid SHALL rise exactly H+2 cycles after the accepting edge, independent of operand values, including exceptions.
REQ-017 No new accept SHALL occur in the same cycle as the result handshake. in_ready rises on the cycle after out_valid falls.
REQ-018 Inputs presented while in_ready=0 SHALL be ignored and SHALL NOT corrupt the in-flight operation.

Reset
REQ-019 On a clock edge with rst=1, regardless of state, the block SHALL do all of the following:
- FSM goes to IDLE; step counter = 0.
- in_ready=1 on the following cycle; out_valid=0.
- result, exception, overflow, underflow and zero all = 0.
REQ-020 An in-flight operation interrupted by reset SHALL be discarded and SHALL produce no output.
REQ-021 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-022 Normal: a=0x40400000, b=0x40000000 (3.0*2.0), out_ready=1 -> result 0x40C00000, all flags 0, out_valid 26 cycles after accept.
REQ-023 Normalise/round: a=b=0x3FC00000 (1.5*1.5) -> 0x40100000; a=b=0x3F800000 -> 0x3F800000, zero=0.
REQ-024 Overflow/underflow:
- 0x7F000000*0x40000000 -> 0x7F800000, overflow=1.
- 0x00800000*0x00800000 -> 0x00000000, underflow=1.
REQ-025 Exception/zero:
- 0x7F800000*0x3F800000 -> 0x00000000, exception=1.
- 0x80000000*0x3F800000 -> 0x80000000, zero=1.
REQ-026 Handshake/reset:
- Hold out_ready=0 for 10 cycles: result stable, in_ready=0, and a second in_valid pulse is ignored.
- Assert rst at MUL step 5: out_valid is never asserted, and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/fp_mult_seq.sv
// Iterative single-issue floating-point multiplier: radix-2 shift-add significand
// multiply over H cycles, then one cycle of normalise/round/pack.
module fp_mult_seq #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23,
    parameter int unsigned TRUNC_BITS = 0,
    parameter int unsigned BIT_WIDTH  = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a_operand,
    input  logic [BIT_WIDTH-1:0] b_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 exception,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 zero
);

    localparam int unsigned H  = MANT_WIDTH + 1;
    localparam int unsigned PW = 2 * H;
    localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned EW = EXP_WIDTH + 2;
    localparam logic [EW-1:0] Bias = EW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic [EW-1:0] ExpMax = EW'((2 ** EXP_WIDTH) - 1);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]   a_q, a_d;
    logic                   b_sign_q, b_sign_d;
    logic [EXP_WIDTH-1:0]   b_exp_q, b_exp_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [H-1:0]           mplier_q, mplier_d;
    logic [BIT_WIDTH-1:0]   result_q, result_d;
    logic                   exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

    logic [EXP_WIDTH-1:0]   a_exp, in_b_exp;
    logic [H-1:0]           a_sig;
    logic [H:0]             step_sum;
    logic [PW-1:0]          trunc_mask, prod_t;
    logic                   norm, guard, sticky, round_carry, sign;
    logic [PW-2:0]          prod_n;
    logic [MANT_WIDTH:0]    mant_sum;
    logic [EW-1:0]          exp_sum;
    logic                   n_exc, n_zero, n_ovf, n_unf;
    logic [BIT_WIDTH-1:0]   n_result;

    assign a_exp    = a_q[BIT_WIDTH-2 -: EXP_WIDTH];
    assign in_b_exp = b_operand[BIT_WIDTH-2 -: EXP_WIDTH];
    assign a_sig    = {|a_exp, a_q[MANT_WIDTH-1:0]};
    assign sign     = a_q[BIT_WIDTH-1] ^ b_sign_q;

    // Add the multiplicand into the upper half, then shift the whole accumulator right.
    assign step_sum = {1'b0, acc_q[PW-1:H]} + (mplier_q[0] ? {1'b0, a_sig} : '0);

    always_comb begin
        trunc_mask = '1;
        for (int i = 0; i < int'(TRUNC_BITS); i++) begin
            trunc_mask[i] = 1'b0;
        end
        prod_t      = acc_q & trunc_mask;
        norm        = prod_t[PW-1];
        prod_n      = norm ? prod_t[PW-2:0] : {prod_t[PW-3:0], 1'b0};
        guard       = prod_n[MANT_WIDTH];
        sticky      = |prod_n[MANT_WIDTH-1:0];
        mant_sum    = {1'b0, prod_n[PW-2:MANT_WIDTH+1]} + (MANT_WIDTH+1)'(guard & sticky);
        round_carry = mant_sum[MANT_WIDTH];
        exp_sum     = {2'b00, a_exp} + {2'b00, b_exp_q} - Bias + EW'(norm) + EW'(round_carry);

        n_exc  = (&a_exp) | (&b_exp_q);
        n_zero = !n_exc && (acc_q == '0);
        n_ovf  = !n_exc && !n_zero && ($signed(exp_sum) >= $signed(ExpMax));
        n_unf  = !n_exc && !n_zero && !n_ovf && ($signed(exp_sum) <= $signed(EW'(0)));

        if (n_exc) begin
            n_result = '0;
        end else if (n_zero || n_unf) begin
            n_result = {sign, {(BIT_WIDTH-1){1'b0}}};
        end else if (n_ovf) begin
            n_result = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else begin
            n_result = {sign, exp_sum[EXP_WIDTH-1:0], mant_sum[MANT_WIDTH-1:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_sign_d = b_sign_q;
        b_exp_d  = b_exp_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        result_d = result_q;
        exc_d    = exc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = a_operand;
                    b_sign_d = b_operand[BIT_WIDTH-1];
                    b_exp_d  = in_b_exp;
                    acc_d    = '0;
                    mplier_d = {|in_b_exp, b_operand[MANT_WIDTH-1:0]};
                    cnt_d    = '0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                acc_d    = {step_sum, acc_q[H-1:1]};
                mplier_d = {1'b0, mplier_q[H-1:1]};
                if (cnt_q == CW'(H - 1)) begin
                    cnt_d   = '0;
                    state_d = StNorm;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StNorm: begin
                result_d = n_result;
                exc_d    = n_exc;
                ovf_d    = n_ovf;
                unf_d    = n_unf;
                zero_d   = n_zero;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_sign_q <= 1'b0;
            b_exp_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_sign_q <= b_sign_d;
            b_exp_q  <= b_exp_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign exception = exc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq (binary32 defaults): directed and random products checked against
// an arithmetic reference model, plus latency, back-pressure and reset behaviour.
module tb_fp_mult_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a_operand, b_operand, result;
    logic        exception, overflow, underflow, zero;

    int tests = 0;
    int fails = 0;

    fp_mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {exception, overflow, underflow, zero, result}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e, m, norm, carry, g, st;
        logic [63:0] sa, sb, p, pn;
        logic        s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        sa = 64'(a[22:0]) + ((ea != 0) ? 64'h80_0000 : 64'h0);
        sb = 64'(b[22:0]) + ((eb != 0) ? 64'h80_0000 : 64'h0);
        p  = sa * sb;
        if (ea == 255 || eb == 255) return {4'b1000, 32'h0};
        if (p == 64'h0) return {4'b0001, s, 31'h0};
        norm = int'(p[47]);
        pn   = (norm == 1) ? p : (p << 1);
        g    = int'(pn[23]);
        st   = (pn[22:0] != 23'h0) ? 1 : 0;
        m    = int'(pn[46:24]) + (g & st);
        carry = 0;
        if (m == 32'h80_0000) begin
            m     = 0;
            carry = 1;
        end
        e = ea + eb - 127 + norm + carry;
        if (e >= 255) return {4'b0100, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0010, s, 31'h0};
        return {4'b0000, s, e[7:0], m[22:0]};
    endfunction

    // One transaction; out_ready is withheld for 'hold' cycles once out_valid is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                         input string tag);
        logic [35:0] exp;
        int          lat;
        exp = ref_mul(a, b);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 2;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid) lat++;
            else break;
        end
        // Counts edges from the accepting edge through the edge that raises out_valid.
        chk({tag, "_latency"}, 64'(lat), 64'd26);
        chk({tag, "_result"}, 64'(result), 64'(exp[31:0]));
        chk({tag, "_flags"}, 64'({exception, overflow, underflow, zero}), 64'(exp[35:32]));
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                in_valid  = 1'b1;
                a_operand = 32'h4040_0000;
                b_operand = 32'h4040_0000;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'({out_valid, in_ready}), 64'b10);
            chk({tag, "_hold_result"}, 64'({exception, overflow, underflow, zero, result}),
                64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_after_hs"}, 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_again"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_operand = '0;
        b_operand = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_handshake", 64'({in_ready, out_valid}), 64'b10);
        chk("reset_outputs", 64'({exception, overflow, underflow, zero, result}), 64'd0);

        do_op(32'h4040_0000, 32'h4000_0000, 0, "mul_3x2");
        chk("mul_3x2_const", 64'(ref_mul(32'h4040_0000, 32'h4000_0000)), 64'h0_40C0_0000);
        do_op(32'h3FC0_0000, 32'h3FC0_0000, 0, "mul_1p5sq");
        do_op(32'h3F80_0000, 32'h3F80_0000, 0, "mul_one");
        do_op(32'h7F00_0000, 32'h4000_0000, 0, "overflow");
        do_op(32'h0080_0000, 32'h0080_0000, 0, "underflow");
        do_op(32'h7F80_0000, 32'h3F80_0000, 0, "exception");
        do_op(32'h8000_0000, 32'h3F80_0000, 0, "neg_zero");
        do_op(32'hC040_0000, 32'h4000_0000, 10, "backpressure");

        // Reset in the middle of MUL, with a fresh in_valid held alongside it.
        @(negedge clk);
        a_operand = 32'h4040_0000;
        b_operand = 32'h4000_0000;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_handshake", 64'({in_ready, out_valid}), 64'b10);
        chk("midrst_outputs", 64'({exception, overflow, underflow, zero, result}), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_output", 64'(seen), 64'd0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 4 != 0) begin
                ra[30:23] = 8'($urandom_range(96, 160));
                rb[30:23] = 8'($urandom_range(96, 160));
            end
            if (n % 9 == 5) rb[30:0] = 31'h0;
            if (n % 11 == 7) ra[30:23] = 8'($urandom_range(0, 3));
            do_op(ra, rb, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
